// File: rtl/acc_fifo_port.sv
// acc_fifo_port: router put/get FIFO endpoint with sticky overflow/underflow flags and flush on disable
module acc_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             empty,
    output logic             full,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    output logic             push_drop,
    output logic             pop_drop
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d, push_ok, pop_ok;

    assign empty    = count_q == '0;
    assign full     = count_q == (AW+1)'(DEPTH);
    assign rd_data  = data_q;
    assign rd_valid = valid_q;

    // A push while full is refused even if a pop frees a slot on the same edge.
    always_comb begin
        push_ok   = en & push & ~full;
        pop_ok    = en & pop & ~empty;
        push_drop = en & push & full;
        pop_drop  = en & pop & empty;
        wr_ptr_d  = en ? wr_ptr_q + AW'(push_ok) : '0;
        rd_ptr_d  = en ? rd_ptr_q + AW'(pop_ok) : '0;
        count_d   = en ? count_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok) : '0;
        valid_d   = pop_ok;
        data_d    = pop_ok ? mem_q[rd_ptr_q] : data_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_data;
    end
endmodule

module acc_fifo_port #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             acc_enable,
    input  logic             put_req,
    input  logic [WIDTH-1:0] put_data,
    output logic             to_acc_empty,
    output logic             to_acc_full,
    input  logic             acc_rd_req,
    output logic [WIDTH-1:0] acc_rd_data,
    output logic             acc_rd_valid,
    input  logic             acc_wr_req,
    input  logic [WIDTH-1:0] acc_wr_data,
    input  logic             get_req,
    output logic [WIDTH-1:0] get_data,
    output logic             get_valid,
    output logic             from_acc_empty,
    output logic             from_acc_full,
    output logic             overflow,
    output logic             underflow
);
    logic in_pdrop, in_udrop, out_pdrop, out_udrop;
    logic overflow_q, overflow_d, underflow_q, underflow_d;

    acc_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_in (
        .clk(clk), .reset(reset), .en(acc_enable),
        .push(put_req), .push_data(put_data), .pop(acc_rd_req),
        .empty(to_acc_empty), .full(to_acc_full),
        .rd_data(acc_rd_data), .rd_valid(acc_rd_valid),
        .push_drop(in_pdrop), .pop_drop(in_udrop)
    );

    acc_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_out (
        .clk(clk), .reset(reset), .en(acc_enable),
        .push(acc_wr_req), .push_data(acc_wr_data), .pop(get_req),
        .empty(from_acc_empty), .full(from_acc_full),
        .rd_data(get_data), .rd_valid(get_valid),
        .push_drop(out_pdrop), .pop_drop(out_udrop)
    );

    assign overflow  = overflow_q;
    assign underflow = underflow_q;

    always_comb begin
        overflow_d  = overflow_q | in_pdrop | out_pdrop;
        underflow_d = underflow_q | in_udrop | out_udrop;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end
endmodule

// File: tb/tb_acc_fifo_port.sv
// tb_acc_fifo_port: table vectors, directed corner cases and random traffic against a queue-based model
module tb_acc_fifo_port;
    localparam int W = 32;
    localparam int D = 8;

    logic         clk = 1'b0, reset = 1'b0, acc_enable = 1'b0;
    logic         put_req = 1'b0, acc_rd_req = 1'b0, acc_wr_req = 1'b0, get_req = 1'b0;
    logic [W-1:0] put_data = '0, acc_wr_data = '0;
    logic         to_acc_empty, to_acc_full, acc_rd_valid, get_valid;
    logic         from_acc_empty, from_acc_full, overflow, underflow;
    logic [W-1:0] acc_rd_data, get_data;

    always #5 clk = ~clk;

    acc_fifo_port #(.WIDTH(W), .DEPTH(D), .AW(3)) dut (
        .clk(clk), .reset(reset), .acc_enable(acc_enable),
        .put_req(put_req), .put_data(put_data),
        .to_acc_empty(to_acc_empty), .to_acc_full(to_acc_full),
        .acc_rd_req(acc_rd_req), .acc_rd_data(acc_rd_data), .acc_rd_valid(acc_rd_valid),
        .acc_wr_req(acc_wr_req), .acc_wr_data(acc_wr_data),
        .get_req(get_req), .get_data(get_data), .get_valid(get_valid),
        .from_acc_empty(from_acc_empty), .from_acc_full(from_acc_full),
        .overflow(overflow), .underflow(underflow)
    );

    int n_chk = 0, n_pass = 0;

    logic [W-1:0] iq[$], oq[$];
    logic [W-1:0] m_rd, m_get;
    logic         m_rv, m_gv, m_ovf, m_udf;

    typedef struct {
        logic         put, rd;
        logic [W-1:0] pd;
        logic         e_empty, e_full, e_rv;
        logic [W-1:0] e_rd;
        logic         e_ovf, e_udf;
    } vec_t;
    vec_t tbl[18];

    function automatic vec_t mk(logic put, logic rd, logic [W-1:0] pd, logic ee, logic ef,
                                logic rv, logic [W-1:0] er, logic ov, logic un);
        vec_t v;
        v.put = put; v.rd = rd; v.pd = pd; v.e_empty = ee; v.e_full = ef;
        v.e_rv = rv; v.e_rd = er; v.e_ovf = ov; v.e_udf = un;
        return v;
    endfunction

    task automatic chk(string name, logic [W-1:0] act, logic [W-1:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic model_reset();
        iq.delete(); oq.delete();
        m_rd = '0; m_get = '0; m_rv = 1'b0; m_gv = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;
    endtask

    task automatic check_all(string tag);
        chk({tag, " to_acc_empty"},   W'(to_acc_empty),   W'(iq.size() == 0));
        chk({tag, " to_acc_full"},    W'(to_acc_full),    W'(iq.size() == D));
        chk({tag, " from_acc_empty"}, W'(from_acc_empty), W'(oq.size() == 0));
        chk({tag, " from_acc_full"},  W'(from_acc_full),  W'(oq.size() == D));
        chk({tag, " acc_rd_valid"},   W'(acc_rd_valid),   W'(m_rv));
        chk({tag, " acc_rd_data"},    acc_rd_data,        m_rd);
        chk({tag, " get_valid"},      W'(get_valid),      W'(m_gv));
        chk({tag, " get_data"},       get_data,           m_get);
        chk({tag, " overflow"},       W'(overflow),       W'(m_ovf));
        chk({tag, " underflow"},      W'(underflow),      W'(m_udf));
    endtask

    // Apply one cycle of requests, advance the model by the protocol rules, compare everything.
    task automatic step(string tag, logic en, logic put, logic [W-1:0] pd, logic rd,
                        logic wr, logic [W-1:0] wd, logic get);
        bit pu, po, wu, go;
        acc_enable = en; put_req = put; put_data = pd; acc_rd_req = rd;
        acc_wr_req = wr; acc_wr_data = wd; get_req = get;
        @(posedge clk); #1;
        if (!en) begin
            iq.delete(); oq.delete(); m_rv = 1'b0; m_gv = 1'b0;
        end else begin
            pu = put && iq.size() < D;
            po = rd && iq.size() > 0;
            wu = wr && oq.size() < D;
            go = get && oq.size() > 0;
            m_ovf = m_ovf | (put && !pu) | (wr && !wu);
            m_udf = m_udf | (rd && !po) | (get && !go);
            m_rv = po; m_gv = go;
            if (po) m_rd = iq.pop_front();
            if (go) m_get = oq.pop_front();
            if (pu) iq.push_back(pd);
            if (wu) oq.push_back(wd);
        end
        check_all(tag);
    endtask

    initial begin
        model_reset();
        for (int i = 0; i < 8; i++) tbl[i] = mk(1'b1, 1'b0, 32'h100 + i, 1'b0, 1'(i == 7), 1'b0, '0, 1'b0, 1'b0);
        tbl[8] = mk(1'b1, 1'b0, 32'hDEAD, 1'b0, 1'b1, 1'b0, '0, 1'b1, 1'b0);
        for (int k = 0; k < 8; k++) tbl[9 + k] = mk(1'b0, 1'b1, '0, 1'(k == 7), 1'b0, 1'b1, 32'h100 + k, 1'b1, 1'b0);
        tbl[17] = mk(1'b0, 1'b1, '0, 1'b1, 1'b0, 1'b0, 32'h107, 1'b1, 1'b1);

        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        check_all("reset");

        for (int i = 0; i < 18; i++) begin
            step("tbl", 1'b1, tbl[i].put, tbl[i].pd, tbl[i].rd, 1'b0, '0, 1'b0);
            chk($sformatf("tbl%0d empty", i), W'(to_acc_empty), W'(tbl[i].e_empty));
            chk($sformatf("tbl%0d full", i),  W'(to_acc_full),  W'(tbl[i].e_full));
            chk($sformatf("tbl%0d valid", i), W'(acc_rd_valid), W'(tbl[i].e_rv));
            chk($sformatf("tbl%0d data", i),  acc_rd_data,      tbl[i].e_rd);
            chk($sformatf("tbl%0d ovf", i),   W'(overflow),     W'(tbl[i].e_ovf));
            chk($sformatf("tbl%0d udf", i),   W'(underflow),    W'(tbl[i].e_udf));
        end

        for (int i = 0; i < 3; i++) step("out_fill", 1'b1, 1'b0, '0, 1'b0, 1'b1, 32'hA0 + i, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step("push_pop", 1'b1, 1'b0, '0, 1'b0, 1'b1, 32'hB0 + i, 1'b1);
            chk("push_pop get_valid", W'(get_valid), W'(1));
            chk("push_pop not_empty", W'(from_acc_empty), W'(0));
        end
        for (int i = 0; i < 4; i++) step("out_drain", 1'b1, 1'b0, '0, 1'b0, 1'b0, '0, 1'b1);

        for (int i = 0; i < 8; i++) step("in_fill", 1'b1, 1'b1, 32'hC0 + i, 1'b0, 1'b0, '0, 1'b0);
        step("full_rd_put", 1'b1, 1'b1, 32'hBEEF, 1'b1, 1'b0, '0, 1'b0);
        chk("full_rd_put not_full", W'(to_acc_full), W'(0));
        for (int i = 0; i < 8; i++) step("in_drain", 1'b1, 1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
        step("get_empty", 1'b1, 1'b0, '0, 1'b0, 1'b0, '0, 1'b1);

        for (int i = 0; i < 5; i++) step("load", 1'b1, 1'b1, 32'hD0 + i, 1'b0, i < 2, 32'hE0 + i, 1'b0);
        step("flush", 1'b0, 1'b1, 32'h77, 1'b1, 1'b1, 32'h88, 1'b1);
        chk("flush in_empty", W'(to_acc_empty), W'(1));
        chk("flush out_empty", W'(from_acc_empty), W'(1));
        step("post_flush", 1'b1, 1'b0, '0, 1'b1, 1'b0, '0, 1'b1);

        for (int i = 0; i < 1500; i++)
            step("rand", $urandom_range(0, 19) != 0, 1'($urandom), $urandom, 1'($urandom),
                 1'($urandom), $urandom, 1'($urandom));

        for (int i = 0; i < 3; i++) step("pre_rst", 1'b1, 1'b1, 32'h55 + i, 1'b0, 1'b1, 32'h66 + i, 1'b0);
        #2 reset = 1'b0;
        #1;
        chk("async to_acc_empty",   W'(to_acc_empty),   W'(1));
        chk("async to_acc_full",    W'(to_acc_full),    W'(0));
        chk("async from_acc_empty", W'(from_acc_empty), W'(1));
        chk("async from_acc_full",  W'(from_acc_full),  W'(0));
        chk("async acc_rd_valid",   W'(acc_rd_valid),   W'(0));
        chk("async acc_rd_data",    acc_rd_data,        W'(0));
        chk("async get_valid",      W'(get_valid),      W'(0));
        chk("async get_data",       get_data,           W'(0));
        chk("async overflow",       W'(overflow),       W'(0));
        chk("async underflow",      W'(underflow),      W'(0));
        model_reset();
        put_req = 1'b0; acc_rd_req = 1'b0; acc_wr_req = 1'b0; get_req = 1'b0;
        @(negedge clk) reset = 1'b1;
        @(posedge clk); #1;
        check_all("post_rst");
        for (int i = 0; i < 50; i++)
            step("rand2", 1'b1, 1'($urandom), $urandom, 1'($urandom), 1'($urandom), $urandom, 1'($urandom));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
